data_mem_slave: RTL
===================

Name: data_mem_slave

Overview:
Responder end of the data-memory bus driven by the MEM stage. It accepts ce/we/sel/addr/data requests and holds an on-chip word-addressed RAM with per-byte-lane writes. It inserts a programmable number of wait states, stalling the pipeline through stall_req_o until the access completes, and returns full 32-bit read words; byte and halfword extraction stays in the MEM stage. It sits between the MEM stage and the pipeline control/stall unit.

Parameters:
WAIT_STATES, 2, extra BUSY cycles before the array access (0..15).
ADDR_W, 10, word-address width; depth = 2^ADDR_W words.
BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
ce_i  in  1  request strobe (`ChipEnable`).
we_i  in  1  1 = write, 0 = read (`WriteEnable`).
addr_i  in  32  byte address; addr_i[1:0] is ignored for array indexing.
data_i  in  32  write data, already lane-replicated by the requester.
sel_i  in  4  byte lanes, big-endian: sel[3]=bits 31:24 (offset 0) ... sel[0]=bits 7:0 (offset 3).
flush_i  in  1  pipeline flush or exception; aborts an in-flight access.
data_o  out  32  read word, valid while ack_o=1.
stall_req_o  out  1  request to freeze the pipeline.
ack_o  out  1  access complete, one cycle wide.
err_o  out  1  address out of range, qualified by ack_o.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, cnt=0, data_o=0, ack_o=0, err_o=0, stall_req_o=0. RAM contents are not cleared.
- Reset mid-access: any pending write is dropped and no array write occurs.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - stall_req_o = ce_i & ~flush_i (combinational).
  - If ce_i & ~flush_i: capture addr, we, sel, data; cnt <= WAIT_STATES; go to BUSY.
- BUSY:
  - stall_req_o=1.
  - Inputs are ignored; the captured request is authoritative.
  - flush_i=1 -> go to IDLE, no write, no ack.
  - cnt!=0 -> cnt--.
  - cnt==0 -> perform the access and go to DONE.
    - Write: update only the lanes whose sel bit is set. sel=0000 writes nothing.
    - Read: rdata <= whole word.
  - Range check: index = (addr - BASE_ADDR) >> 2. If (addr - BASE_ADDR) >= 4*2^ADDR_W, then out of range: no write, rdata=0, err flag set.
- DONE:
  - stall_req_o=0, ack_o=1, data_o=rdata, err_o=err flag.
  - Next state is IDLE.
  - A ce_i in DONE is ignored; the requester re-presents it in IDLE. The pipeline advances on this cycle, so a back-to-back request is seen in the following cycle.
  - flush_i in DONE has no effect, because the access is already committed.
- Latency: request seen in cycle T -> array access at T+1+WAIT_STATES -> ack/data at T+2+WAIT_STATES. The stall lasts WAIT_STATES+2 cycles.
- data_o holds its last read value outside DONE. It is 0 after a write or an error.
- Misaligned addresses are not checked here; that check belongs to the MEM stage.

Decomposition:
- Shared defines in defines.v: `RegBus`, `ChipEnable`/`ChipDisable`, `WriteEnable`/`WriteDisable`, `ZeroWord`, `RstEnable` (1'b1), and the FSM state encodings `DMS_IDLE`/`DMS_BUSY`/`DMS_DONE` (2 bits).
- One sub-module, data_ram_array:
  - four 8-bit banks of 2^ADDR_W entries;
  - synchronous write with 4-bit lane enable;
  - asynchronous read of the full word.
  - The FSM, counter, range check and flush handling stay in data_mem_slave.

Test Plan:
1. WAIT_STATES=2: write addr=0x10, data=0x11223344, sel=1111. Expected: stall high for 4 cycles, ack in cycle T+4. Then read 0x10 -> data_o=0x11223344 with ack, err_o=0.
2. Byte write: addr=0x11, data=0xAAAAAAAA, sel=0100, over word 0x11223344. Expected: a read of 0x10 returns 0x11AA3344.
3. Halfword write: sel=0011, data=0xBEEF_BEEF. Expected: a read returns 0x11AABEEF. A write with sel=0000 leaves the word unchanged.
4. Out of range: read 0x0000_1000 (ADDR_W=10). Expected: ack=1, err_o=1, data_o=0. A write to the same address alters no word, checked by reading back words 0 and 1023.
5. flush_i asserted in the first BUSY cycle of a write of 0xDEADBEEF to 0x20. Expected: no ack, FSM back in IDLE, and a later read of 0x20 returns the old value.
6. Async rst pulse mid-BUSY during a write, then back-to-back reads. Expected: outputs go to 0 immediately and the write is lost. WAIT_STATES=0 reads give ack at T+2, and a second request presented in the cycle after DONE is accepted.

Source files
------------

// File: rtl/data_mem_slave_pkg.sv
// Shared widths, bus constants, FSM encoding and request payload for the data-memory slave.
package data_mem_slave_pkg;

  localparam int unsigned REG_W = 32;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 4;

  localparam logic             CHIP_ENABLE  = 1'b1;
  localparam logic             WRITE_ENABLE = 1'b1;
  localparam logic             RST_ENABLE   = 1'b1;
  localparam logic [REG_W-1:0] ZERO_WORD    = '0;

  typedef enum logic [1:0] {
    DMS_IDLE = 2'b00,
    DMS_BUSY = 2'b01,
    DMS_DONE = 2'b10
  } dms_state_e;

  typedef struct packed {
    logic [REG_W-1:0] addr;
    logic             we;
    logic [SEL_W-1:0] sel;
    logic [REG_W-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/data_ram_array.sv
// Word-addressed RAM built from four byte banks; lane-enabled synchronous write, asynchronous read.
module data_ram_array
  import data_mem_slave_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] index,
  input  logic [SEL_W-1:0]  lane_we,
  input  logic [REG_W-1:0]  wdata,
  output logic [REG_W-1:0]  rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  for (genvar b = 0; b < SEL_W; b++) begin : g_bank
    logic [7:0] mem [DEPTH];

    // Byte lane b holds bits 8b+7:8b; sel bit b enables it.
    always_ff @(posedge clk) begin
      if (lane_we[b]) mem[index] <= wdata[8*b +: 8];
    end

    assign rdata[8*b +: 8] = mem[index];
  end

endmodule

// File: rtl/data_mem_slave.sv
// Data-memory bus responder: captures a request, waits WAIT_STATES cycles, accesses the RAM, acks once.
module data_mem_slave
  import data_mem_slave_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_i,
  input  logic             we_i,
  input  logic [REG_W-1:0] addr_i,
  input  logic [REG_W-1:0] data_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             flush_i,
  output logic [REG_W-1:0] data_o,
  output logic             stall_req_o,
  output logic             ack_o,
  output logic             err_o
);

  dms_state_e        state;
  dms_state_e        state_nxt;
  logic [CNT_W-1:0]  cnt;
  mem_req_t          req;
  logic              start;
  logic              access;
  logic [REG_W-1:0]  offset;
  logic              out_of_range;
  logic [ADDR_W-1:0] index;
  logic [SEL_W-1:0]  lane_we;
  logic [REG_W-1:0]  rdata;

  assign start        = (ce_i == CHIP_ENABLE) && !flush_i;
  assign offset       = req.addr - BASE_ADDR;
  assign out_of_range = ({32'b0, offset} >= (64'd4 << ADDR_W));
  assign index        = offset[ADDR_W+1:2];
  assign access       = (state == DMS_BUSY) && !flush_i && (cnt == '0);
  assign lane_we      = (access && (req.we == WRITE_ENABLE) && !out_of_range) ? req.sel : '0;

  data_ram_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .index   (index),
    .lane_we (lane_we),
    .wdata   (req.data),
    .rdata   (rdata)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) state <= DMS_IDLE;
    else                   state <= state_nxt;
  end

  // Next state and pipeline stall request.
  always_comb begin
    state_nxt   = state;
    stall_req_o = 1'b0;
    unique case (state)
      DMS_IDLE: begin
        stall_req_o = start;
        if (start) state_nxt = DMS_BUSY;
      end
      DMS_BUSY: begin
        stall_req_o = 1'b1;
        if (flush_i)        state_nxt = DMS_IDLE;
        else if (cnt == '0) state_nxt = DMS_DONE;
      end
      DMS_DONE: state_nxt = DMS_IDLE;
      default:  state_nxt = DMS_IDLE;
    endcase
  end

  // Request capture, wait counter and registered response (ack/err live for the DONE cycle only).
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      cnt    <= '0;
      req    <= '0;
      data_o <= ZERO_WORD;
      ack_o  <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      unique case (state)
        DMS_IDLE: begin
          if (start) begin
            req <= '{addr: addr_i, we: we_i, sel: sel_i, data: data_i};
            cnt <= CNT_W'(WAIT_STATES);
          end
        end
        DMS_BUSY: begin
          if (!flush_i) begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              ack_o  <= 1'b1;
              err_o  <= out_of_range;
              data_o <= ((req.we != WRITE_ENABLE) && !out_of_range) ? rdata : ZERO_WORD;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
